// File: rtl/gray_conv_pkg.sv
// Shared constants and helpers for the pipelined Gray/binary converter.
// Provides mode encodings, segment sizing and reference conversions.
package gray_conv_pkg;

   localparam logic MODE_G2B = 1'b0;
   localparam logic MODE_B2G = 1'b1;

   // Bits of the Gray prefix chain resolved per stage (ceil division).
   function automatic int seg_width(input int width, input int stages);
      return (width + stages - 1) / stages;
   endfunction

   function automatic logic [63:0] gray2bin(input logic [63:0] g,
                                            input int width);
      logic [63:0] b;
      logic run;
      b = '0;
      run = 1'b0;
      for (int i = 63; i >= 0; i--) begin
         if (i < width) begin
            run = run ^ g[i];
            b[i] = run;
         end
      end
      return b;
   endfunction

   function automatic logic [63:0] bin2gray(input logic [63:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One pipeline stage: resolves its slice of the Gray prefix chain
// (mode 0) or, as stage 0, forms the whole Gray code (mode 1).
// Ports: clk, rst; up_valid/up_data/up_mode/carry from the previous
// stage; down_ready = next stage will load; valid/data/mode registered
// result; load = this stage takes a word on the next edge.
// Optional (GRAY_CONV_PARITY_EN): parity = XOR-reduce of data.
module gray_conv_stage
   import gray_conv_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int IDX    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             up_mode,
   input  logic             carry,
   input  logic             down_ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             mode,
   output logic             load
`ifdef GRAY_CONV_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam int SEG = seg_width(WIDTH, STAGES);
   localparam int HI  = WIDTH - 1 - IDX * SEG;
   localparam int LO  = (HI - SEG + 1 < 0) ? 0 : HI - SEG + 1;

   logic [WIDTH-1:0] nxt;
   logic             run;

   // Bits outside this segment pass through: above it they are already
   // binary, below it they are still the original Gray bits.
   always_comb begin
      nxt = up_data;
      run = carry;
      if (up_mode == MODE_G2B) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i <= HI && i >= LO) begin
               run = run ^ up_data[i];
               nxt[i] = run;
            end
         end
      end else if (IDX == 0) begin
         nxt = up_data ^ (up_data >> 1);
      end
   end

   assign load = !valid || down_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         mode  <= 1'b0;
`ifdef GRAY_CONV_PARITY_EN
         parity <= 1'b0;
`endif
      end else if (load) begin
         valid <= up_valid;
         if (up_valid) begin
            data <= nxt;
            mode <= up_mode;
`ifdef GRAY_CONV_PARITY_EN
            parity <= ^nxt;
`endif
         end
      end
   end

endmodule

// File: rtl/gray_code_converter_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on
// both sides. Ports: clk, rst (async, active high); in_valid/in_ready/
// in_data/in_mode (0 = Gray->bin, 1 = bin->Gray); out_valid/out_ready/
// out_data/out_mode. Optional macro GRAY_CONV_PARITY_EN adds
// out_parity = XOR-reduce of out_data. Latency is STAGES cycles.
module gray_code_converter_pipe
   import gray_conv_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_mode
`ifdef GRAY_CONV_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   localparam int SEG = seg_width(WIDTH, STAGES);

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] ld;
   logic [WIDTH-1:0]  dat  [STAGES];
   logic              md   [STAGES];
   logic              up_v [STAGES];
   logic [WIDTH-1:0]  up_d [STAGES];
   logic              up_m [STAGES];
   logic              up_c [STAGES];
   logic              dn_r [STAGES];
`ifdef GRAY_CONV_PARITY_EN
   logic              par  [STAGES];
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Carry into stage k is the last bit resolved by stage k-1.
      localparam int LOP = (WIDTH - k * SEG < 0) ? 0 : WIDTH - k * SEG;

      if (k == 0) begin : g_first
         assign up_v[k] = in_valid;
         assign up_d[k] = in_data;
         assign up_m[k] = in_mode;
         assign up_c[k] = 1'b0;
      end else begin : g_mid
         assign up_v[k] = vld[k-1];
         assign up_d[k] = dat[k-1];
         assign up_m[k] = md[k-1];
         assign up_c[k] = dat[k-1][LOP];
      end

      // Ready ripples back combinationally from out_ready.
      if (k == STAGES - 1) begin : g_last
         assign dn_r[k] = out_ready;
      end else begin : g_inner
         assign dn_r[k] = ld[k+1];
      end

      gray_conv_stage #(
         .WIDTH (WIDTH),
         .STAGES(STAGES),
         .IDX   (k)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .up_valid  (up_v[k]),
         .up_data   (up_d[k]),
         .up_mode   (up_m[k]),
         .carry     (up_c[k]),
         .down_ready(dn_r[k]),
         .valid     (vld[k]),
         .data      (dat[k]),
         .mode      (md[k]),
         .load      (ld[k])
`ifdef GRAY_CONV_PARITY_EN
         ,
         .parity    (par[k])
`endif
      );
   end

   assign in_ready  = ld[0];
   assign out_valid = vld[STAGES-1];
   assign out_data  = dat[STAGES-1];
   assign out_mode  = md[STAGES-1];
`ifdef GRAY_CONV_PARITY_EN
   assign out_parity = par[STAGES-1];
`endif

endmodule

// File: doc/gray_code_converter_pipe.md
Name: gray_code_converter_pipe

Overview:
- Parametrised, pipelined bidirectional Gray/binary converter with valid/ready handshake on both sides.
- Generalises the 4-bit combinational Gray-to-binary decoder:
  - configurable width;
  - per-transaction mode (Gray to binary or binary to Gray);
  - configurable pipeline depth that splits the long XOR prefix chain.
- Sits between counter/CDC pointer logic and downstream arithmetic. Back-pressure is supported without data loss.

Parameters:
- WIDTH, 8, data width in bits; legal range 2..64.
- STAGES, 2, pipeline register stages; legal range 1..4, and STAGES must be <= WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  converter can accept a word this cycle.
- in_data  input  WIDTH  word to convert.
- in_mode  input  1  0 = Gray to binary, 1 = binary to Gray; sampled with in_data.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  converted word.
- out_mode  output  1  mode that produced out_data.

Behaviour:
- Reset:
  - rst asserted asynchronously clears all stage valid flags and forces out_valid = 0, out_data = 0, out_mode = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - Stage data registers are also cleared.
- Transfers:
  - An input transfer occurs on a clk edge where in_valid && in_ready.
  - An output transfer occurs on a clk edge where out_valid && out_ready.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no back-pressure.
- Throughput: one word per cycle while out_ready = 1.
- Pipeline control:
  - Each stage k holds valid_k, partial data, the original input word and mode.
  - Stage k loads when !valid_k || advance_{k+1}, where the last stage advances on out_ready.
  - in_ready = !valid_0 || advance_1.
  - This is combinational from out_ready; no skid buffer is used.
- Stall: with out_ready = 0 and all stages full, in_ready = 0. Held data is unchanged. out_data/out_mode are stable while out_valid && !out_ready.
- Bubbles: empty stages collapse. A word entering an empty pipeline behind a stalled word advances until it is directly behind that word.
- Gray to binary (mode 0):
  - b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i], computed MSB first.
  - The chain is split into STAGES segments of ceil(WIDTH/STAGES) bits, MSB segment first.
  - Each stage resolves its segment using the carried-in running XOR bit.
  - If WIDTH is not divisible by STAGES, the last segment is shorter.
- Binary to Gray (mode 1):
  - g = b ^ (b >> 1), computed in stage 0 and passed through the remaining stages unchanged.
  - Latency is identical to mode 0.
- Mixed modes: modes can alternate every cycle. Ordering is strictly FIFO and no reordering occurs.
- Simultaneous input and output transfer on a full pipeline is legal and sustains full rate.
- Reset mid-operation: all in-flight words are discarded and no out_valid pulse follows reset.
- in_data/in_mode are don't-care while in_valid = 0.

Optional Feature:
- Macro: GRAY_CONV_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR-reduce of out_data, registered with out_data and stable under stall.
  - Resets to 0.
  - In mode 0 this equals out_data[0] ^ ... and it is cross-checked against the input: parity of the binary result equals the XOR of the prefix bits.
  - The bench compares it against a model.
- Undefined: the port and its logic are absent. Ports and timing are otherwise identical.

Decomposition:
- Package gray_conv_pkg:
  - localparam MODE_G2B = 1'b0 and MODE_B2G = 1'b1;
  - function seg_width(WIDTH, STAGES) returning ceil(WIDTH/STAGES);
  - reference functions gray2bin/bin2gray for assertions.
- Sub-module gray_conv_stage, one per pipeline stage:
  - inputs: segment index, carried XOR bit, word, mode, valid;
  - outputs: registered partial result and valid;
  - contains the local load/advance logic.
- The top level contains the generate loop and the ready chain.

Test Plan:
- Reset then single word, WIDTH=8, STAGES=2: in_data=0xC6, mode 0 -> out_data=0x84 and out_mode=0 exactly 2 cycles later; in_ready=1 throughout.
- Mode 1, in_data=0x84 -> 0xC6. Mode 1, 0xFF -> 0x80. Mode 0, 0x80 -> 0xFF. Sent back-to-back -> outputs in order on consecutive cycles.
- Back-pressure: hold out_ready=0 while streaming 0x01,0x02,0x03 -> in_ready falls after 2 words accepted; out_data stays 0x01 (mode 1) stable; releasing out_ready drains 0x01,0x03,0x02 (Gray) in order with no loss or duplicate.
- Exhaustive sweep, WIDTH=8, STAGES in {1,3,4}, all 256 values in both modes, random out_ready -> matches package reference functions; a round trip bin2gray then gray2bin equals the input.
- Reset mid-stream: assert rst with 2 words in flight -> out_valid=0 immediately (asynchronous) and no output appears after release.
- GRAY_CONV_PARITY_EN defined, mode 0, in_data=0xC6 -> out_parity=0 (0x84 has two set bits); mode 1, 0x01 -> out_data=0x01, out_parity=1.
